// File: rtl/tm_qm_mem_mp.sv
// Queue association memory: self-clearing table with round-robin app read ports
// and a staged wide-word PIO path sharing one single-port RAM.
`ifndef QUEUE_ASSOCIATION_NBITS
`define QUEUE_ASSOCIATION_NBITS 40
`endif
`ifndef FIRST_LVL_QUEUE_ID_NBITS
`define FIRST_LVL_QUEUE_ID_NBITS 10
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif

module tm_qm_mem_mp #(
  parameter int DATA_NBITS = `QUEUE_ASSOCIATION_NBITS,
  parameter int ADDR_NBITS = `FIRST_LVL_QUEUE_ID_NBITS,
  parameter int N_PORTS    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           reg_ms,
  input  logic                           reg_rd,
  input  logic                           reg_wr,
  input  logic [`PIO_RANGE]              reg_addr,
  input  logic [`PIO_RANGE]              reg_din,
  output logic                           mem_ack,
  output logic [`PIO_RANGE]              mem_rdata,
  input  logic [N_PORTS-1:0]             app_mem_rd,
  input  logic [N_PORTS*ADDR_NBITS-1:0]  app_mem_raddr,
  output logic [N_PORTS-1:0]             app_mem_ack,
  output logic [N_PORTS*DATA_NBITS-1:0]  app_mem_rdata,
  output logic                           init_done
);

  localparam int DEPTH     = 2**ADDR_NBITS;
  localparam int NWORDS    = (DATA_NBITS + 31) / 32;
  localparam int WSEL      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int NSTAGE    = (NWORDS > 1) ? NWORDS - 1 : 1;
  localparam int PAD_NBITS = NWORDS * 32;
  localparam int PTR_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [ADDR_NBITS-1:0] LAST_ENTRY = ADDR_NBITS'(DEPTH - 1);

  typedef enum logic {T_INIT, T_RUN} top_state_t;
  typedef enum logic [1:0] {P_IDLE, P_REQ, P_RESP} pio_state_t;

  top_state_t              top_state_reg, top_state_next;
  pio_state_t              pio_state_reg, pio_state_next;
  logic [ADDR_NBITS-1:0]   init_cnt_reg;
  logic                    init_done_reg;

  logic                    pio_wr_reg;
  logic [ADDR_NBITS-1:0]   pio_entry_reg;
  logic [WSEL-1:0]         pio_wsel_reg;
  logic [31:0]             pio_din_reg;
  logic [31:0]             staging_reg [NSTAGE];

  logic [N_PORTS-1:0]      pend_reg;
  logic [ADDR_NBITS-1:0]   raddr_reg [N_PORTS];
  logic [PTR_W-1:0]        ptr_reg;
  logic [N_PORTS-1:0]      ack_reg;
  logic [DATA_NBITS-1:0]   held_reg [N_PORTS];

  logic [DATA_NBITS-1:0]   mem [DEPTH];
  logic [DATA_NBITS-1:0]   rd_data_reg;

  logic                    pio_accept;
  logic                    req_ram;
  logic [WSEL-1:0]         req_wsel;
  logic [ADDR_NBITS-1:0]   req_entry;
  logic [PAD_NBITS-1:0]    commit_pad;
  logic [PAD_NBITS-1:0]    rd_pad;
  logic                    ram_we;
  logic                    ram_re;
  logic [ADDR_NBITS-1:0]   ram_addr;
  logic [DATA_NBITS-1:0]   ram_wdata;
  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic [N_PORTS-1:0]      grant_vec;
  logic                    unused_ok;

  assign req_wsel   = reg_addr[WSEL-1:0];
  assign req_entry  = reg_addr[ADDR_NBITS+WSEL-1:WSEL];
  assign pio_accept = (pio_state_reg == P_IDLE) && reg_ms && (reg_rd || reg_wr);
  // Only reads and last-word writes touch the RAM; lower-word writes just stage.
  assign req_ram    = !reg_wr || (req_wsel == WSEL'(NWORDS - 1));
  assign rd_pad     = PAD_NBITS'(rd_data_reg);
  assign unused_ok  = &{1'b0, reg_addr, commit_pad};
  assign init_done  = init_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS - 1; gi++) begin : g_commit
      assign commit_pad[gi*32 +: 32] = staging_reg[gi];
    end
  endgenerate
  assign commit_pad[PAD_NBITS-1 -: 32] = pio_din_reg;

  // State register process for both FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_state_reg <= T_INIT;
      pio_state_reg <= P_IDLE;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      top_state_reg <= top_state_next;
      pio_state_reg <= pio_state_next;
      if (top_state_reg == T_INIT) init_cnt_reg <= init_cnt_reg + 1'b1;
      init_done_reg <= (top_state_next == T_RUN);
    end
  end

  always_comb begin
    top_state_next = top_state_reg;
    if (top_state_reg == T_INIT && init_cnt_reg == LAST_ENTRY) top_state_next = T_RUN;

    pio_state_next = pio_state_reg;
    case (pio_state_reg)
      P_IDLE:  if (pio_accept) pio_state_next = req_ram ? P_REQ : P_RESP;
      P_REQ:   if (top_state_reg == T_RUN) pio_state_next = P_RESP;
      P_RESP:  pio_state_next = P_IDLE;
      default: pio_state_next = P_IDLE;
    endcase
  end

  // Round-robin pick: the first pending port at offset 0.. from the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (!grant_any && pend_reg[j] && ((int'(ptr_reg) + i) % N_PORTS == j)) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(j);
        end
      end
    end
  end

  // Output process: one RAM access per cycle, init > PIO > app ports.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    grant_vec = '0;
    if (top_state_reg == T_INIT) begin
      ram_we   = 1'b1;
      ram_addr = init_cnt_reg;
    end else if (pio_state_reg == P_REQ) begin
      ram_we    = pio_wr_reg;
      ram_re    = !pio_wr_reg;
      ram_addr  = pio_entry_reg;
      ram_wdata = commit_pad[DATA_NBITS-1:0];
    end else if (grant_any) begin
      ram_re               = 1'b1;
      ram_addr             = raddr_reg[grant_idx];
      grant_vec[grant_idx] = 1'b1;
    end

    mem_ack   = (pio_state_reg == P_RESP);
    mem_rdata = '0;
    if (mem_ack && !pio_wr_reg && int'(pio_wsel_reg) < NWORDS)
      mem_rdata = rd_pad[pio_wsel_reg*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (ram_re) rd_data_reg   <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pio_wr_reg    <= 1'b0;
      pio_entry_reg <= '0;
      pio_wsel_reg  <= '0;
      pio_din_reg   <= '0;
      for (int w = 0; w < NSTAGE; w++) staging_reg[w] <= '0;
    end else if (pio_accept) begin
      pio_wr_reg    <= reg_wr;
      pio_entry_reg <= req_entry;
      pio_wsel_reg  <= req_wsel;
      pio_din_reg   <= reg_din;
      for (int w = 0; w < NSTAGE; w++)
        if (reg_wr && w < NWORDS - 1 && req_wsel == WSEL'(w)) staging_reg[w] <= reg_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      ack_reg  <= '0;
      ptr_reg  <= '0;
      for (int k = 0; k < N_PORTS; k++) begin
        raddr_reg[k] <= '0;
        held_reg[k]  <= '0;
      end
    end else begin
      ack_reg <= grant_vec;
      if (grant_any)
        ptr_reg <= (grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      for (int k = 0; k < N_PORTS; k++) begin
        if (grant_vec[k]) begin
          pend_reg[k] <= 1'b0;
        end else if (app_mem_rd[k] && !pend_reg[k]) begin
          pend_reg[k]  <= 1'b1;
          raddr_reg[k] <= app_mem_raddr[k*ADDR_NBITS +: ADDR_NBITS];
        end
        if (ack_reg[k]) held_reg[k] <= rd_data_reg;
      end
    end
  end

  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      // Fresh RAM data during the ack cycle, then the held copy until the next ack.
      assign app_mem_rdata[gi*DATA_NBITS +: DATA_NBITS] = ack_reg[gi] ? rd_data_reg : held_reg[gi];
      assign app_mem_ack[gi] = ack_reg[gi];
`ifndef SYNTHESIS
      a_no_rd_while_pend: assert property (@(posedge clk) disable iff (!rst_n)
        !(app_mem_rd[gi] && pend_reg[gi]));
`endif
    end
  endgenerate

endmodule

// File: tb/tb_tm_qm_mem_mp.sv
// Directed bench for tm_qm_mem_mp: 40-bit entries, 16 entries, 3 app ports.
module tb_tm_qm_mem_mp;

  localparam int DW = 40;
  localparam int AW = 4;
  localparam int NP = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           reg_ms = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0;
  logic [31:0]    reg_addr = '0, reg_din = '0;
  logic           mem_ack;
  logic [31:0]    mem_rdata;
  logic [NP-1:0]  app_mem_rd = '0;
  logic [NP*AW-1:0] app_mem_raddr = '0;
  logic [NP-1:0]  app_mem_ack;
  logic [NP*DW-1:0] app_mem_rdata;
  logic           init_done;

  int n_checks = 0;
  int n_errors = 0;

  tm_qm_mem_mp #(.DATA_NBITS(DW), .ADDR_NBITS(AW), .N_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_ms(reg_ms), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    return app_mem_rdata[k*DW +: DW];
  endfunction

  task automatic pio(input logic wr, input logic [AW-1:0] entry, input logic ws,
                     input logic [31:0] din, output logic [31:0] rdata, output int lat);
    reg_ms = 1'b1; reg_wr = wr; reg_rd = !wr;
    reg_addr = {27'd0, entry, ws}; reg_din = din;
    step();
    reg_ms = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    lat = 1;
    while (!mem_ack && lat < 20) begin step(); lat++; end
    rdata = mem_rdata;
    step();
  endtask

  task automatic pio_wr(input logic [AW-1:0] entry, input logic ws, input logic [31:0] din,
                        input int exp_lat, input string tag);
    logic [31:0] rd; int lat;
    pio(1'b1, entry, ws, din, rd, lat);
    check({tag, "_lat"}, lat, exp_lat);
    $display("pio wr entry=%0d ws=%0d din=%h lat=%0d", entry, ws, din, lat);
  endtask

  task automatic pio_rd(input logic [AW-1:0] entry, input logic ws, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd; int lat;
    pio(1'b0, entry, ws, 32'd0, rd, lat);
    check({tag, "_lat"}, lat, 2);
    check(tag, rd, exp);
    $display("pio rd entry=%0d ws=%0d data=%h lat=%0d", entry, ws, rd, lat);
  endtask

  task automatic app_rd(input int k, input logic [AW-1:0] entry, input logic [DW-1:0] exp,
                        input string tag);
    int lat;
    app_mem_rd[k] = 1'b1;
    app_mem_raddr[k*AW +: AW] = entry;
    step();
    app_mem_rd = '0;
    lat = 1;
    while (!app_mem_ack[k] && lat < 20) begin step(); lat++; end
    check({tag, "_lat"}, lat, 2);
    check(tag, port_data(k), exp);
    $display("app rd port=%0d entry=%0d data=%h lat=%0d", k, entry, port_data(k), lat);
    step();
  endtask

  // Expected ack vectors at offsets 1..6 after a three-way request.
  logic [NP-1:0] seq_fwd [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
  logic [NP-1:0] seq_rot [6] = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
  logic [DW-1:0] ent_val [NP] = '{40'h11_A0000001, 40'h22_A0000002, 40'h33_A0000003};

  task automatic burst(input logic [NP-1:0] exp_seq [6], input string tag);
    app_mem_raddr = {4'd3, 4'd2, 4'd1};
    app_mem_rd = 3'b111;
    step();
    app_mem_rd = '0;
    for (int off = 1; off <= 6; off++) begin
      check(tag, app_mem_ack, exp_seq[off-1]);
      for (int k = 0; k < NP; k++)
        if (exp_seq[off-1][k]) check({tag, "_data"}, port_data(k), ent_val[k]);
      $display("%s off=%0d ack=%b", tag, off, app_mem_ack);
      step();
    end
  endtask

  initial begin
    int cnt, acks;
    repeat (3) step();
    check("rst_init_done", init_done, 0);
    check("rst_mem_ack", mem_ack, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_app_ack", app_mem_ack, 0);
    check("rst_app_data", port_data(0), 0);
    rst_n = 1'b1;
    cnt = 0;
    while (!init_done && cnt < 100) begin step(); cnt++; end
    check("init_cycles", cnt, 16);
    $display("init done after %0d cycles", cnt);
    for (int e = 0; e < 16; e++) begin
      pio_rd(AW'(e), 1'b0, 32'd0, "init_w0");
      pio_rd(AW'(e), 1'b1, 32'd0, "init_w1");
    end

    // Wide PIO write to entry 5, read back via app port and PIO.
    pio_wr(4'd5, 1'b0, 32'hDEADBEEF, 1, "wide_w0");
    pio_wr(4'd5, 1'b1, 32'h000001A5, 2, "wide_w1");
    app_rd(0, 4'd5, 40'hA5_DEADBEEF, "wide_app");
    step(); step();
    check("wide_held", port_data(0), 40'hA5_DEADBEEF);
    pio_rd(4'd5, 1'b1, 32'h000000A5, "wide_pio_w1");
    pio_rd(4'd5, 1'b0, 32'hDEADBEEF, "wide_pio_w0");
    app_rd(2, 4'd5, 40'hA5_DEADBEEF, "port2_rd");

    // Entries 1..3 for the contention bursts; upper word bits above 40 are dropped.
    for (int e = 1; e <= 3; e++) begin
      pio_wr(AW'(e), 1'b0, 32'hA0000000 + 32'(e), 1, "cont_w0");
      pio_wr(AW'(e), 1'b1, 32'hFFFFFF00 | 32'(e * 17), 2, "cont_w1");
    end
    pio_rd(4'd1, 1'b1, 32'h00000011, "discard_hi");
    burst(seq_fwd, "cont_fwd");
    app_rd(0, 4'd1, ent_val[0], "rr_port0");
    burst(seq_rot, "cont_rot");

    // PIO commit and app read of entry 7 in the same cycle.
    pio_wr(4'd7, 1'b0, 32'h77777777, 1, "prio_w0");
    reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = {27'd0, 4'd7, 1'b1}; reg_din = 32'h42;
    app_mem_rd[1] = 1'b1; app_mem_raddr[7:4] = 4'd7;
    step();
    reg_ms = 1'b0; reg_wr = 1'b0; app_mem_rd = '0;
    for (int off = 1; off <= 4; off++) begin
      check("prio_mem_ack", mem_ack, off == 2);
      check("prio_app_ack", app_mem_ack, (off == 3) ? 3'b010 : 3'b000);
      if (off == 3) check("prio_data", port_data(1), 40'h42_77777777);
      $display("prio off=%0d mem_ack=%b app_ack=%b", off, mem_ack, app_mem_ack);
      step();
    end

    // Top entry, no aliasing onto entry 0.
    pio_wr(4'd15, 1'b0, 32'hCAFEF00D, 1, "top_w0");
    pio_wr(4'd15, 1'b1, 32'h0000005A, 2, "top_w1");
    app_rd(1, 4'd15, 40'h5A_CAFEF00D, "top_app");
    pio_rd(4'd0, 1'b0, 32'd0, "alias_w0");
    pio_rd(4'd0, 1'b1, 32'd0, "alias_w1");

    // Both strobes high count as a write (staging, ack after one cycle, no read data).
    reg_ms = 1'b1; reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = {27'd0, 4'd9, 1'b0}; reg_din = 32'h12345678;
    step();
    reg_ms = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    check("both_ack", mem_ack, 1);
    check("both_rdata", mem_rdata, 0);
    step();
    pio_wr(4'd9, 1'b1, 32'h0, 2, "both_commit");
    pio_rd(4'd9, 1'b0, 32'h12345678, "both_rd");

    // Reset clears held data; then reset again mid-sweep with reads pending.
    rst_n = 1'b0; #1;
    check("rst2_data", port_data(1), 0);
    check("rst2_init_done", init_done, 0);
    step(); rst_n = 1'b1;
    repeat (8) step();
    app_mem_raddr = {4'd0, 4'd2, 4'd1};
    app_mem_rd = 3'b011;
    step();
    app_mem_rd = '0;
    step();
    rst_n = 1'b0; #1;
    check("midrst_ack", app_mem_ack, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_mem_ack", mem_ack, 0);
    step(); rst_n = 1'b1;
    cnt = 0; acks = 0;
    while (!init_done && cnt < 100) begin
      step(); cnt++;
      if (app_mem_ack != 0) acks++;
    end
    check("resweep_cycles", cnt, 16);
    repeat (8) begin step(); if (app_mem_ack != 0) acks++; end
    check("lost_reqs", acks, 0);
    $display("resweep cycles=%0d stray acks=%0d", cnt, acks);

    // A read issued during init waits for the sweep and sees cleared data.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin step(); cnt++; end
    app_mem_rd[2] = 1'b1; app_mem_raddr[11:8] = 4'd15;
    step(); cnt++;
    app_mem_rd = '0;
    while (!app_mem_ack[2] && cnt < 60) begin step(); cnt++; end
    check("init_latched_cycle", cnt, 17);
    check("init_latched_data", port_data(2), 0);
    $display("init-latched read acked at cycle %0d data=%h", cnt, port_data(2));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
